regfile_wr_arb: RTL and testbench
=================================

# regfile_wr_arb

Write-port arbiter placed between the writeback stage and the register file. It merges two result sources into the register file's single write port: the in-order pipeline writeback and a long-latency unit (divider or uncached load) that uses a valid/ready handshake. Long-latency results queue in a small FIFO. A starvation counter guarantees the queued results get the port. A pending-register bitmap lets decode stall on registers whose values are still in flight.

## Interface
- XLEN, 64, data and PC width
- AW, 5, register address width
- DEPTH, 2, long-latency FIFO entries (power of 2, ≥2)
- STARVE_MAX, 4, cycles a FIFO head may wait before the pipeline is stalled (≥1)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pipe_valid_i  in  1  pipeline writeback valid (no ready; always accepted unless stall_o)
- pipe_addr_i  in  AW  pipeline destination register
- pipe_data_i  in  XLEN  pipeline result
- pipe_pc_i  in  XLEN  PC of retiring instruction
- ll_valid_i  in  1  long-latency result valid
- ll_ready_o  out  1  FIFO can accept
- ll_addr_i  in  AW  long-latency destination
- ll_data_i  in  XLEN  long-latency result
- ll_pc_i  in  XLEN  PC of long-latency instruction
- stall_o  out  1  upstream must hold pipeline writeback this cycle
- wr_en_o  out  1  register file write enable (registered)
- wr_addr_o  out  AW  register file write address (registered)
- wr_data_o  out  XLEN  register file write data (registered)
- pc_wb_o  out  XLEN  committed PC for diff-test, 0 when nothing commits (registered)
- pend_o  out  32  bit n set: xn has a buffered or registered-but-unwritten result

## Operation
- FIFO push: ll_valid_i && ll_ready_o at the edge. ll_ready_o = (count != DEPTH), driven from the count register. No push when full, even if a pop occurs in the same cycle.
- Selection each cycle, in priority order:
  - (a) stall_o: pop FIFO head.
  - (b) pipe_valid_i: take the pipeline entry.
  - (c) FIFO non-empty: pop head.
  - (d) idle.
- Push and pop in the same cycle are legal. Count is unchanged, and the head comes from the existing entry, never the incoming one.
- Output register loads the selected entry: wr_addr_o, wr_data_o, pc_wb_o.
  - wr_en_o = 1 only if the selected entry's address ≠ 0.
  - An x0 entry is consumed with wr_en_o = 0, but pc_wb_o still carries its PC.
  - Idle: wr_en_o = 0 and pc_wb_o = 0. wr_addr_o and wr_data_o hold their values.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- stall_o = (counter == STARVE_MAX) && non-empty. It is combinational from registers only, never from inputs.
- pipe_valid_i high while stall_o is high is an upstream protocol error. The entry is dropped and a simulation assertion fires.
- pend_o = OR of one-hot(addr) over valid FIFO entries, plus one-hot(wr_addr_o) when wr_en_o. Bit 0 is always 0.
- Ordering: FIFO order is preserved. WAW ordering between the two sources is guaranteed by the upstream scoreboard, not by this block.

## Timing
- Reset (asynchronous assert, synchronous release edge):
  - FIFO empty and counter = 0.
  - wr_en_o = 0, wr_addr_o = 0, wr_data_o = 0, pc_wb_o = 0.
  - stall_o = 0, pend_o = 0, ll_ready_o = 1.
- Reset mid-operation discards all FIFO contents and any registered write.
- Pipeline latency: pipe_valid_i at edge t gives wr_en_o high during cycle t+1.
- Long-latency latency: a push at edge t is popped at the earliest edge t+1, so wr_en_o is high during t+2 at minimum.
- Worst-case wait for a FIFO head: STARVE_MAX cycles, then stall_o for exactly one cycle per starved entry.
- Throughput: one write per cycle. Sustained long-latency input at one per cycle with no pipeline traffic never fills the FIFO.
- The register file sees wr_* one cycle after arbitration. pend_o covers that window, so decode must stall on pend_o.

## Test plan
- Pipeline only: pipe_valid_i=1, addr=5, data=0xAA, pc=0x80000000 at edge 1 -> during cycle 2: wr_en_o=1, wr_addr_o=5, wr_data_o=0xAA, pc_wb_o=0x80000000; cycle 3 idle gives pc_wb_o=0.
- x0 write: pipe addr=0, pc=0x80000004 -> wr_en_o=0, pc_wb_o=0x80000004, pend_o=0.
- Long-latency alone: ll push addr=10, data=0x1234 at edge 1 -> pend_o[10]=1 from cycle 2; wr_en_o=1, wr_addr_o=10 during cycle 3; pend_o=0 after that write edge.
- Fill and backpressure (DEPTH=2): with pipe_valid_i held high, push ll entries 1 and 2 -> ll_ready_o=0; a third ll_valid_i is not accepted until a pop occurs.
- Starvation (STARVE_MAX=4): one ll entry queued, pipe_valid_i continuously high -> stall_o=1 on the 5th cycle after the push; FIFO head written next cycle; stall_o back to 0.
- Reset mid-operation: two entries queued, rst_n low -> immediately ll_ready_o=1, pend_o=0, wr_en_o=0; no queued entry is written after release.

Source files
------------

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: merges pipeline writeback and a queued long-latency
// result stream onto the single register file write port.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   pipe_valid_i/addr_i/data_i/pc_i    in-order writeback (no ready)
//   ll_valid_i/addr_i/data_i/pc_i      long-latency result, with ll_ready_o
//   stall_o                            upstream must hold writeback
//   wr_en_o/addr_o/data_o, pc_wb_o     registered write port + commit PC
//   pend_o                             per-register in-flight bitmap
module regfile_wr_arb #(
  parameter int XLEN       = 64,
  parameter int AW         = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_valid_i,
  input  logic [AW-1:0]   pipe_addr_i,
  input  logic [XLEN-1:0] pipe_data_i,
  input  logic [XLEN-1:0] pipe_pc_i,
  input  logic            ll_valid_i,
  output logic            ll_ready_o,
  input  logic [AW-1:0]   ll_addr_i,
  input  logic [XLEN-1:0] ll_data_i,
  input  logic [XLEN-1:0] ll_pc_i,
  output logic            stall_o,
  output logic            wr_en_o,
  output logic [AW-1:0]   wr_addr_o,
  output logic [XLEN-1:0] wr_data_o,
  output logic [XLEN-1:0] pc_wb_o,
  output logic [31:0]     pend_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [AW-1:0]   f_addr [DEPTH];
  logic [XLEN-1:0] f_data [DEPTH];
  logic [XLEN-1:0] f_pc   [DEPTH];
  logic [DEPTH-1:0] f_vld;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve;

  logic            empty;
  logic            push;
  logic            pop;
  logic            take_pipe;
  logic            sel_valid;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;
  logic [XLEN-1:0] sel_pc;
  logic [31:0]     pend;

  assign empty      = (count == '0);
  assign ll_ready_o = (count != CW'(DEPTH));
  assign push       = ll_valid_i && ll_ready_o;
  assign stall_o    = !empty && (starve == SW'(STARVE_MAX));

  // A starved head wins; otherwise the FIFO only drains in pipeline gaps.
  assign pop       = !empty && (stall_o || !pipe_valid_i);
  assign take_pipe = pipe_valid_i && !stall_o;

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_pc    = '0;
    unique case (1'b1)
      pop: begin
        sel_valid = 1'b1;
        sel_addr  = f_addr[rd_ptr];
        sel_data  = f_data[rd_ptr];
        sel_pc    = f_pc[rd_ptr];
      end
      take_pipe: begin
        sel_valid = 1'b1;
        sel_addr  = pipe_addr_i;
        sel_data  = pipe_data_i;
        sel_pc    = pipe_pc_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_addr[wr_ptr] <= ll_addr_i;
      f_data[wr_ptr] <= ll_data_i;
      f_pc[wr_ptr]   <= ll_pc_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      f_vld     <= '0;
      starve    <= '0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      pc_wb_o   <= '0;
    end else begin
      if (push) begin
        wr_ptr         <= wr_ptr + PW'(1);
        f_vld[wr_ptr]  <= 1'b1;
      end
      if (pop) begin
        rd_ptr         <= rd_ptr + PW'(1);
        f_vld[rd_ptr]  <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (empty || pop) begin
        starve <= '0;
      end else if (starve != SW'(STARVE_MAX)) begin
        starve <= starve + SW'(1);
      end
      if (sel_valid) begin
        wr_en_o   <= (sel_addr != '0);
        wr_addr_o <= sel_addr;
        wr_data_o <= sel_data;
        pc_wb_o   <= sel_pc;
      end else begin
        wr_en_o   <= 1'b0;
        pc_wb_o   <= '0;
      end
    end
  end

  function automatic logic [31:0] onehot(input logic [AW-1:0] a);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = (int'(a) == i);
    end
    return r;
  endfunction

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (f_vld[i]) pend = pend | onehot(f_addr[i]);
    end
    if (wr_en_o) pend = pend | onehot(wr_addr_o);
    pend[0] = 1'b0;
  end

  assign pend_o = pend;

  a_no_pipe_on_stall: assert property (
    @(posedge clk) disable iff (!rst_n) !(pipe_valid_i && stall_o)
  );

endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb_regfile_wr_arb: directed vector table plus reset sequence
// for the register file write-port arbiter.
module tb_regfile_wr_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_valid_i;
  logic [4:0]  pipe_addr_i;
  logic [63:0] pipe_data_i;
  logic [63:0] pipe_pc_i;
  logic        ll_valid_i;
  logic        ll_ready_o;
  logic [4:0]  ll_addr_i;
  logic [63:0] ll_data_i;
  logic [63:0] ll_pc_i;
  logic        stall_o;
  logic        wr_en_o;
  logic [4:0]  wr_addr_o;
  logic [63:0] wr_data_o;
  logic [63:0] pc_wb_o;
  logic [31:0] pend_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wr_arb #(
    .XLEN(64), .AW(5), .DEPTH(2), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid_i(pipe_valid_i), .pipe_addr_i(pipe_addr_i),
    .pipe_data_i(pipe_data_i), .pipe_pc_i(pipe_pc_i),
    .ll_valid_i(ll_valid_i), .ll_ready_o(ll_ready_o),
    .ll_addr_i(ll_addr_i), .ll_data_i(ll_data_i), .ll_pc_i(ll_pc_i),
    .stall_o(stall_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .pc_wb_o(pc_wb_o), .pend_o(pend_o)
  );

  typedef struct {
    logic        pv;
    logic [4:0]  pa;
    logic [63:0] pd;
    logic [63:0] pp;
    logic        lv;
    logic [4:0]  la;
    logic [63:0] ld;
    logic [63:0] lp;
    logic        en;
    logic [4:0]  a;
    logic [63:0] d;
    logic [63:0] pc;
    logic [31:0] pend;
    logic        rdy;
    logic        stl;
  } vec_t;

  function automatic vec_t mk(
    input logic pv, input logic [4:0] pa,
    input logic [63:0] pd, input logic [63:0] pp,
    input logic lv, input logic [4:0] la,
    input logic [63:0] ld, input logic [63:0] lp,
    input logic en, input logic [4:0] a,
    input logic [63:0] d, input logic [63:0] pc,
    input logic [31:0] pend, input logic rdy, input logic stl);
    vec_t v;
    v.pv = pv; v.pa = pa; v.pd = pd; v.pp = pp;
    v.lv = lv; v.la = la; v.ld = ld; v.lp = lp;
    v.en = en; v.a = a; v.d = d; v.pc = pc;
    v.pend = pend; v.rdy = rdy; v.stl = stl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pipe_valid_i = v.pv; pipe_addr_i = v.pa;
    pipe_data_i  = v.pd; pipe_pc_i   = v.pp;
    ll_valid_i   = v.lv; ll_addr_i   = v.la;
    ll_data_i    = v.ld; ll_pc_i     = v.lp;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, ".wr_en"},   64'(wr_en_o),    64'(v.en));
    chk({tag, ".wr_addr"}, 64'(wr_addr_o),  64'(v.a));
    chk({tag, ".wr_data"}, wr_data_o,       v.d);
    chk({tag, ".pc_wb"},   pc_wb_o,         v.pc);
    chk({tag, ".pend"},    64'(pend_o),     64'(v.pend));
    chk({tag, ".ready"},   64'(ll_ready_o), 64'(v.rdy));
    chk({tag, ".stall"},   64'(stall_o),    64'(v.stl));
  endtask

  localparam int NV = 21;
  vec_t tv [NV];
  vec_t z;

  initial begin
    tv[0]  = mk(1, 5, 'hAA, 'h80000000, 0, 0, 0, 0,
                1, 5, 'hAA, 'h80000000, 32'h20, 1, 0);
    tv[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                0, 5, 'hAA, 0, 0, 1, 0);
    tv[2]  = mk(1, 0, 'h55, 'h80000004, 0, 0, 0, 0,
                0, 0, 'h55, 'h80000004, 0, 1, 0);
    tv[3]  = mk(0, 0, 0, 0, 1, 10, 'h1234, 'h100,
                0, 0, 'h55, 0, 32'h400, 1, 0);
    tv[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                1, 10, 'h1234, 'h100, 32'h400, 1, 0);
    tv[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                0, 10, 'h1234, 0, 0, 1, 0);
    tv[6]  = mk(1, 1, 'h11, 'h200, 1, 2, 'h22, 'h300,
                1, 1, 'h11, 'h200, 32'h6, 1, 0);
    tv[7]  = mk(1, 3, 'h33, 'h204, 1, 4, 'h44, 'h304,
                1, 3, 'h33, 'h204, 32'h1C, 0, 0);
    tv[8]  = mk(1, 6, 'h66, 'h208, 1, 7, 'h77, 'h308,
                1, 6, 'h66, 'h208, 32'h54, 0, 0);
    tv[9]  = mk(0, 0, 0, 0, 1, 7, 'h77, 'h308,
                1, 2, 'h22, 'h300, 32'h14, 1, 0);
    tv[10] = mk(0, 0, 0, 0, 1, 7, 'h77, 'h308,
                1, 4, 'h44, 'h304, 32'h90, 1, 0);
    tv[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                1, 7, 'h77, 'h308, 32'h80, 1, 0);
    tv[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                0, 7, 'h77, 0, 0, 1, 0);
    tv[13] = mk(1, 8, 'h88, 'h400, 1, 9, 'h99, 'h500,
                1, 8, 'h88, 'h400, 32'h300, 1, 0);
    tv[14] = mk(1, 8, 'h81, 'h404, 0, 0, 0, 0,
                1, 8, 'h81, 'h404, 32'h300, 1, 0);
    tv[15] = mk(1, 8, 'h82, 'h408, 0, 0, 0, 0,
                1, 8, 'h82, 'h408, 32'h300, 1, 0);
    tv[16] = mk(1, 8, 'h83, 'h40C, 0, 0, 0, 0,
                1, 8, 'h83, 'h40C, 32'h300, 1, 0);
    tv[17] = mk(1, 8, 'h84, 'h410, 0, 0, 0, 0,
                1, 8, 'h84, 'h410, 32'h300, 1, 1);
    tv[18] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                1, 9, 'h99, 'h500, 32'h200, 1, 0);
    tv[19] = mk(1, 8, 'h85, 'h414, 0, 0, 0, 0,
                1, 8, 'h85, 'h414, 32'h100, 1, 0);
    tv[20] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                0, 8, 'h85, 0, 0, 1, 0);
    z = mk(0, 0, 0, 0, 0, 0, 0, 0,
           0, 0, 0, 0, 0, 1, 0);

    rst_n = 1'b0;
    drive(z);
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset", z);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tv[i]);
      @(posedge clk);
      #1;
      check_vec($sformatf("vec%0d", i), tv[i]);
    end

    drive(mk(1, 13, 'hD, 'h600, 1, 11, 'hB, 'h700,
             0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    drive(mk(1, 14, 'hE, 'h604, 1, 12, 'hC, 'h704,
             0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("mid.full_ready", 64'(ll_ready_o), 64'd0);
    chk("mid.pend", 64'(pend_o), 64'h5800);
    chk("mid.wr_en", 64'(wr_en_o), 64'd1);
    drive(z);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.ready", 64'(ll_ready_o), 64'd1);
    chk("arst.pend", 64'(pend_o), 64'd0);
    chk("arst.wr_en", 64'(wr_en_o), 64'd0);
    chk("arst.stall", 64'(stall_o), 64'd0);
    chk("arst.pc_wb", pc_wb_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post%0d.wr_en", i), 64'(wr_en_o), 64'd0);
      chk($sformatf("post%0d.pc_wb", i), pc_wb_o, 64'd0);
      chk($sformatf("post%0d.pend", i), 64'(pend_o), 64'd0);
    end
    drive(mk(1, 15, 'hF0, 'h800, 0, 0, 0, 0,
             0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("resume.wr_en", 64'(wr_en_o), 64'd1);
    chk("resume.wr_addr", 64'(wr_addr_o), 64'd15);
    chk("resume.pc_wb", pc_wb_o, 64'h800);
    drive(z);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
